// File: rtl/mac_tx.sv
// mac_tx: GMII transmit MAC. AXI-Stream bytes in; preamble, SFD, payload
// (and CRC-32 FCS when MAC_TX_FCS_EN is defined) out, then inter-frame gap.
// Ports: tx_clk, rst (sync, active-high); s_axis_tdata/tvalid/tready/tlast/
// tuser (frame source); gmii_txd/tx_en/tx_er (to PHY); tx_underrun, tx_done
// (one-cycle status pulses). All GMII outputs and pulses are registered.
module mac_tx #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES   = 12
) (
  input  logic       tx_clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       tx_underrun,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, PAYLOAD, FCS, DRAIN, IFG
  } state_t;

  state_t     state, state_n;
  logic [3:0] pre_cnt, pre_cnt_n;
  logic [7:0] ifg_cnt, ifg_cnt_n;
  logic       clean, clean_n;
  logic [7:0] txd_n;
  logic       en_n, er_n, und_n, done_n;

`ifdef MAC_TX_FCS_EN
  logic [31:0] crc, crc_n;
  logic [1:0]  fcs_cnt, fcs_cnt_n;
  logic [31:0] fcs;

  // Reflected CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign fcs = ~crc;
`endif

  // Ready depends on state only, never on tvalid.
  assign s_axis_tready = (state == PAYLOAD) || (state == DRAIN);

  always_comb begin
    state_n   = state;
    pre_cnt_n = pre_cnt;
    ifg_cnt_n = ifg_cnt;
    clean_n   = clean;
    txd_n     = 8'h00;
    en_n      = 1'b0;
    er_n      = 1'b0;
    und_n     = 1'b0;
    done_n    = 1'b0;
`ifdef MAC_TX_FCS_EN
    crc_n     = crc;
    fcs_cnt_n = fcs_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (s_axis_tvalid) begin
          txd_n     = 8'h55;
          en_n      = 1'b1;
          pre_cnt_n = 4'd1;
          state_n   = PREAMBLE;
        end
      end
      PREAMBLE: begin
        en_n = 1'b1;
        if (pre_cnt == 4'(PREAMBLE_LEN)) begin
          txd_n   = 8'hD5;
          state_n = PAYLOAD;
`ifdef MAC_TX_FCS_EN
          crc_n   = '1;
`endif
        end else begin
          txd_n     = 8'h55;
          pre_cnt_n = pre_cnt + 4'd1;
        end
      end
      PAYLOAD: begin
        en_n = 1'b1;
        if (s_axis_tvalid) begin
          txd_n = s_axis_tdata;
`ifdef MAC_TX_FCS_EN
          crc_n = crc_byte(crc, s_axis_tdata);
`endif
          if (s_axis_tlast) begin
            er_n      = s_axis_tuser;
            clean_n   = 1'b1;
            ifg_cnt_n = 8'd0;
`ifdef MAC_TX_FCS_EN
            fcs_cnt_n = 2'd0;
            state_n   = FCS;
`else
            state_n   = IFG;
`endif
          end
        end else begin
          // GMII cannot stall: poison the frame and abort.
          er_n    = 1'b1;
          und_n   = 1'b1;
          state_n = DRAIN;
        end
      end
`ifdef MAC_TX_FCS_EN
      FCS: begin
        en_n      = 1'b1;
        txd_n     = fcs[8*fcs_cnt +: 8];
        fcs_cnt_n = fcs_cnt + 2'd1;
        if (fcs_cnt == 2'd3) begin
          ifg_cnt_n = 8'd0;
          state_n   = IFG;
        end
      end
`endif
      DRAIN: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          clean_n   = 1'b0;
          ifg_cnt_n = 8'd0;
          state_n   = IFG;
        end
      end
      IFG: begin
        // First IFG cycle is the first tx_en-low cycle.
        done_n    = clean && (ifg_cnt == 8'd0);
        ifg_cnt_n = ifg_cnt + 8'd1;
        if (ifg_cnt == 8'(IFG_CYCLES - 1))
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state       <= IDLE;
      pre_cnt     <= 4'd0;
      ifg_cnt     <= 8'd0;
      clean       <= 1'b0;
      gmii_txd    <= 8'h00;
      gmii_tx_en  <= 1'b0;
      gmii_tx_er  <= 1'b0;
      tx_underrun <= 1'b0;
      tx_done     <= 1'b0;
`ifdef MAC_TX_FCS_EN
      crc         <= '1;
      fcs_cnt     <= 2'd0;
`endif
    end else begin
      state       <= state_n;
      pre_cnt     <= pre_cnt_n;
      ifg_cnt     <= ifg_cnt_n;
      clean       <= clean_n;
      gmii_txd    <= txd_n;
      gmii_tx_en  <= en_n;
      gmii_tx_er  <= er_n;
      tx_underrun <= und_n;
      tx_done     <= done_n;
`ifdef MAC_TX_FCS_EN
      crc         <= crc_n;
      fcs_cnt     <= fcs_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_mac_tx.sv
// tb_mac_tx: directed bench for mac_tx (7-byte preamble, 12-cycle IFG).
// Wire bytes are logged by a monitor; checks run in the main sequence.
module tb_mac_tx;

`ifdef MAC_TX_FCS_EN
  localparam int F = 4;
`else
  localparam int F = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic       s_tlast = 1'b0;
  logic       s_tuser = 1'b0;
  logic [7:0] txd;
  logic       tx_en, tx_er, tx_underrun, tx_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] wd[$];
  logic       we[$];
  int         wc[$];
  int         done_c[$];
  int         und_c[$];
  bit         rdy[4096];

  mac_tx #(.PREAMBLE_LEN(7), .IFG_CYCLES(12)) dut (
    .tx_clk(clk),
    .rst(rst),
    .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser),
    .gmii_txd(txd),
    .gmii_tx_en(tx_en),
    .gmii_tx_er(tx_er),
    .tx_underrun(tx_underrun),
    .tx_done(tx_done)
  );

  always #4 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_en) begin
      wd.push_back(txd);
      we.push_back(tx_er);
      wc.push_back(cyc);
    end
    if (tx_done) done_c.push_back(cyc);
    if (tx_underrun) und_c.push_back(cyc);
    if (cyc < 4096) rdy[cyc] = s_tready;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wd.delete();
    we.delete();
    wc.delete();
    done_c.delete();
    und_c.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int er_count();
    int n = 0;
    foreach (we[k]) if (we[k]) n++;
    return n;
  endfunction

  function automatic int rdy_count(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++)
      if (k >= 0 && k < 4096 && rdy[k]) n++;
    return n;
  endfunction

  // stall: byte index at which tvalid drops for one cycle (-1 = none)
  task automatic send_frame(input int len, input int base,
                            input int stall, input bit err);
    int i = 0;
    int g = 0;
    bit hs;
    while (i < len && g < 3000) begin
      g++;
      if (i == stall) begin
        s_tvalid = 1'b0;
        stall = -1;
      end else begin
        s_tvalid = 1'b1;
        s_tdata  = 8'(base + i);
        s_tlast  = (i == len - 1);
        s_tuser  = err && (i == len - 1);
      end
      @(negedge clk);
      hs = s_tvalid && s_tready;
      @(posedge clk);
      #1;
      if (hs) i++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    chk("send_timeout", int'(g < 3000), 1);
  endtask

  initial begin
    int i;
    int g;
    int L;
    bit hs;

    // reset state
    idle(3);
    chk("rst_txd", txd, 0);
    chk("rst_en", tx_en, 0);
    chk("rst_er", tx_er, 0);
    chk("rst_und", tx_underrun, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_rdy", s_tready, 0);
    rst = 1'b0;
    idle(2);

    // 1: 64-byte frame 0x00..0x3F
    clear_log();
    send_frame(64, 0, -1, 1'b0);
    idle(20);
    chk("t1_len", wd.size(), 72 + F);
    for (int k = 0; k < 7; k++) chk("t1_pre", wd[k], 'h55);
    chk("t1_sfd", wd[7], 'hD5);
    for (int k = 0; k < 64; k++) chk("t1_data", wd[8 + k], k);
    chk("t1_contig", wc[71 + F] - wc[0], 71 + F);
    chk("t1_er", er_count(), 0);
    chk("t1_done_n", done_c.size(), 1);
    chk("t1_done_at", done_c[0], wc[71 + F] + 1);

`ifdef MAC_TX_FCS_EN
    // 2: FCS over "123456789" = CBF43926, LSB first
    clear_log();
    send_frame(9, 'h31, -1, 1'b0);
    idle(20);
    chk("t2_len", wd.size(), 21);
    chk("t2_last", wd[16], 'h39);
    chk("t2_fcs0", wd[17], 'h26);
    chk("t2_fcs1", wd[18], 'h39);
    chk("t2_fcs2", wd[19], 'hF4);
    chk("t2_fcs3", wd[20], 'hCB);
    chk("t2_done", done_c.size(), 1);
`endif

    // 3: two 10-byte frames back-to-back
    clear_log();
    send_frame(10, 'h10, -1, 1'b0);
    send_frame(10, 'h20, -1, 1'b0);
    idle(20);
    L = 18 + F;
    chk("t3_len", wd.size(), 2 * L);
    chk("t3_last1", wd[17], 'h19);
    chk("t3_first2", wd[L], 'h55);
    chk("t3_f2_data", wd[L + 8], 'h20);
    chk("t3_gap", wc[L] - wc[L - 1] - 1, 12);
    chk("t3_rdy_gap", rdy_count(wc[L - 1] + 1, wc[L] - 1), 0);
    chk("t3_done_n", done_c.size(), 2);

    // 4: underrun after 5th byte of a 20-byte frame, then a 4-byte frame
    clear_log();
    send_frame(20, 'h40, 5, 1'b0);
    send_frame(4, 'h80, -1, 1'b0);
    idle(20);
    chk("t4_len", wd.size(), 26 + F);
    chk("t4_b5", wd[12], 'h44);
    chk("t4_urun_d", wd[13], 0);
    chk("t4_urun_er", we[13], 1);
    chk("t4_er_total", er_count(), 1);
    chk("t4_und_n", und_c.size(), 1);
    chk("t4_und_at", und_c[0], wc[13]);
    chk("t4_drain_rdy", rdy_count(wc[13], wc[13] + 14), 15);
    chk("t4_gap_ok", int'((wc[14] - wc[13] - 1) >= 12), 1);
    chk("t4_next", wd[14], 'h55);
    chk("t4_done_n", done_c.size(), 1);
    chk("t4_done_at", done_c[0], wc[25 + F] + 1);

    // 5: tuser on tlast of an 8-byte frame
    clear_log();
    send_frame(8, 'hA0, -1, 1'b1);
    idle(20);
    chk("t5_len", wd.size(), 16 + F);
    chk("t5_lastb", wd[15], 'hA7);
    chk("t5_er_last", we[15], 1);
    chk("t5_er_total", er_count(), 1);
    chk("t5_done_n", done_c.size(), 1);

    // 6: reset while payload byte 30 (value 0x1D) is on the wire
    clear_log();
    i = 0;
    g = 0;
    s_tlast = 1'b0;
    s_tuser = 1'b0;
    while (!(tx_en && txd == 8'h1D) && g < 500) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'(i);
      @(negedge clk);
      hs = s_tvalid && s_tready;
      @(posedge clk);
      #1;
      if (hs) i++;
      g++;
    end
    chk("t6_reach", int'(g < 500), 1);
    rst = 1'b1;
    s_tvalid = 1'b0;
    idle(1);
    chk("t6_en", tx_en, 0);
    chk("t6_er", tx_er, 0);
    chk("t6_txd", txd, 0);
    chk("t6_rdy", s_tready, 0);
    rst = 1'b0;
    idle(5);
    chk("t6_no_done", done_c.size(), 0);
    chk("t6_no_und", und_c.size(), 0);
    clear_log();
    send_frame(3, 'hC0, -1, 1'b0);
    idle(20);
    chk("t6_len", wd.size(), 11 + F);
    chk("t6_pre0", wd[0], 'h55);
    chk("t6_pre6", wd[6], 'h55);
    chk("t6_sfd", wd[7], 'hD5);
    chk("t6_b0", wd[8], 'hC0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
